// File: rtl/comb_lock_pkg.sv
// Shared types and width helpers for the combination-lock controller.
package comb_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_e;

    localparam int unsigned DEF_DIGIT_W        = 1;
    localparam int unsigned DEF_DIGITS         = 4;
    localparam int unsigned DEF_MAX_TRIES      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;

    // Width able to hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned tmr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comb_lock_ctrl_if.sv
// Keypad-side strobes and lock/status outputs of the combination-lock controller.
interface comb_lock_ctrl_if
    import comb_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W   = DEF_DIGIT_W,
    parameter int unsigned MAX_TRIES = DEF_MAX_TRIES
);
    localparam int unsigned AW = cnt_w(MAX_TRIES);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               enter;
    logic               set;
    logic               unlocked;
    logic               lockout;
    logic               fail_pulse;
    logic               set_done;
    logic [AW-1:0]      attempts_left;

    modport master (
        output digit_in, digit_valid, enter, set,
        input  unlocked, lockout, fail_pulse, set_done, attempts_left
    );

    modport slave (
        input  digit_in, digit_valid, enter, set,
        output unlocked, lockout, fail_pulse, set_done, attempts_left
    );

endinterface

// File: rtl/comb_lockout_timer.sv
// Loadable down-counter that holds at zero; expired is high whenever the count is zero.
module comb_lockout_timer #(
    parameter int unsigned W = 10
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/comb_lock_ctrl.sv
// Combination-lock controller: digit entry buffer, code check/change, failure count and lockout.
module comb_lock_ctrl
    import comb_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W        = DEF_DIGIT_W,
    parameter int unsigned DIGITS         = DEF_DIGITS,
    parameter logic [DIGIT_W*DIGITS-1:0] RESET_CODE = (DIGIT_W*DIGITS)'(4'b0110),
    parameter int unsigned MAX_TRIES      = DEF_MAX_TRIES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic             Clock,
    input  logic             Reset,
    comb_lock_ctrl_if.slave  bus
);
    localparam int unsigned CW   = DIGIT_W * DIGITS;
    localparam int unsigned CNTW = cnt_w(DIGITS);
    localparam int unsigned AW   = cnt_w(MAX_TRIES);
    localparam int unsigned TW   = tmr_w(LOCKOUT_CYCLES);

    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DIGITS);
    localparam logic [AW-1:0]   MAX_F     = AW'(MAX_TRIES);
    localparam logic [TW-1:0]   TMR_START = TW'(LOCKOUT_CYCLES - 1);

    lock_state_e     state, state_n;
    logic [CW-1:0]   entry, entry_n;
    logic [CW-1:0]   code, code_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [AW-1:0]   fail_cnt, fail_n;
    logic            fail_p, set_p, tmr_load, tmr_expired, full;

    logic            unlocked_q, lockout_q, fail_q, setd_q;
    logic [AW-1:0]   att_q;

    comb_lockout_timer #(.W(TW)) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (tmr_load),
        .value   (TMR_START),
        .expired (tmr_expired)
    );

    assign full = (cnt == FULL_CNT);

    always_comb begin
        state_n  = state;
        entry_n  = entry;
        cnt_n    = cnt;
        code_n   = code;
        fail_n   = fail_cnt;
        fail_p   = 1'b0;
        set_p    = 1'b0;
        tmr_load = 1'b0;
        // enter/set always flush the entry; a digit only lands when no strobe outranks it
        unique case (state)
            LOCKED: begin
                if (bus.enter) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    if (full && entry == code) begin
                        state_n = UNLOCKED;
                        fail_n  = '0;
                    end else begin
                        fail_p = 1'b1;
                        fail_n = fail_cnt + 1'b1;
                        if (fail_n == MAX_F) begin
                            state_n  = LOCKOUT;
                            tmr_load = 1'b1;
                        end
                    end
                end else if (bus.set) begin
                    entry_n = '0;
                    cnt_n   = '0;
                end else if (bus.digit_valid && !full) begin
                    entry_n = (entry << DIGIT_W) | CW'(bus.digit_in);
                    cnt_n   = cnt + 1'b1;
                end
            end
            UNLOCKED: begin
                if (bus.enter) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    state_n = LOCKED;
                end else if (bus.set) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    if (full) begin
                        code_n = entry;
                        set_p  = 1'b1;
                    end
                end else if (bus.digit_valid && !full) begin
                    entry_n = (entry << DIGIT_W) | CW'(bus.digit_in);
                    cnt_n   = cnt + 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_expired) begin
                    state_n = LOCKED;
                    fail_n  = '0;
                end
            end
            default: state_n = LOCKED;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= LOCKED;
            entry      <= '0;
            cnt        <= '0;
            code       <= RESET_CODE;
            fail_cnt   <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            fail_q     <= 1'b0;
            setd_q     <= 1'b0;
            att_q      <= MAX_F;
        end else begin
            state      <= state_n;
            entry      <= entry_n;
            cnt        <= cnt_n;
            code       <= code_n;
            fail_cnt   <= fail_n;
            unlocked_q <= (state_n == UNLOCKED);
            lockout_q  <= (state_n == LOCKOUT);
            fail_q     <= fail_p;
            setd_q     <= set_p;
            att_q      <= MAX_F - fail_n;
        end
    end

    assign bus.unlocked      = unlocked_q;
    assign bus.lockout       = lockout_q;
    assign bus.fail_pulse    = fail_q;
    assign bus.set_done      = setd_q;
    assign bus.attempts_left = att_q;

endmodule
